// File: rtl/adma_chn_wrr_sched.sv
// Weighted-round-robin / fixed-priority channel scheduler for the multi-channel AXI DMA.
// Issues one registered burst grant at a time on a valid/ready handshake.
module adma_chn_wrr_sched #(
    parameter int  CHN_NUM  = 4,
    parameter int  ARB_W    = 3,
    localparam int CHN_ID_W = $clog2(CHN_NUM)
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [CHN_NUM-1:0]       chn_req_i,
    input  logic [CHN_NUM*ARB_W-1:0] chn_wgt_i,
    input  logic                     arb_mode_i,
    output logic                     gnt_valid_o,
    input  logic                     gnt_ready_i,
    output logic [CHN_ID_W-1:0]      gnt_id_o,
    output logic [CHN_NUM-1:0]       gnt_onehot_o
);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t              state_q, state_d;
    logic                valid_q, valid_d;
    logic [CHN_ID_W-1:0] id_q, id_d;
    logic [CHN_NUM-1:0]  onehot_q, onehot_d;
    logic [CHN_ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CHN_ID_W-1:0] cur_q, cur_d;
    logic [ARB_W-1:0]    credit_q, credit_d;
    logic                mode_q, mode_d;

    logic [ARB_W-1:0]    wgt [CHN_NUM];
    logic [CHN_NUM-1:0]  elig;
    logic [CHN_ID_W-1:0] fp_win;
    logic [CHN_ID_W-1:0] rr_win;
    logic [CHN_ID_W-1:0] scan_ptr;
    logic [CHN_ID_W-1:0] win;
    logic                keep_cur;
    logic                early_rel;
    logic                rr_found;
    int                  k;

    function automatic logic [CHN_ID_W-1:0] inc_id(input logic [CHN_ID_W-1:0] id);
        if (id == CHN_ID_W'(CHN_NUM - 1))
            return '0;
        return id + 1'b1;
    endfunction

    always_comb begin
        for (int n = 0; n < CHN_NUM; n++) begin
            wgt[n]  = chn_wgt_i[n*ARB_W +: ARB_W];
            elig[n] = chn_req_i[n] && (wgt[n] != '0);
        end
    end

    always_comb begin
        fp_win = '0;
        for (int i = CHN_NUM - 1; i >= 0; i--) begin
            if (elig[i])
                fp_win = CHN_ID_W'(i);
        end
    end

    // A channel that lost eligibility forfeits its leftover credit.
    assign keep_cur  = elig[cur_q] && (credit_q != '0);
    assign early_rel = !elig[cur_q] && (credit_q != '0);
    assign scan_ptr  = early_rel ? inc_id(cur_q) : rr_ptr_q;

    always_comb begin
        rr_win   = '0;
        rr_found = 1'b0;
        k        = 0;
        for (int i = 0; i < CHN_NUM; i++) begin
            k = int'(scan_ptr) + i;
            if (k >= CHN_NUM)
                k = k - CHN_NUM;
            if (!rr_found && elig[k]) begin
                rr_found = 1'b1;
                rr_win   = CHN_ID_W'(k);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        id_d     = id_q;
        onehot_d = onehot_q;
        rr_ptr_d = rr_ptr_q;
        cur_d    = cur_q;
        credit_d = credit_q;
        mode_d   = mode_q;
        win      = '0;
        unique case (state_q)
            IDLE: begin
                if (!arb_mode_i && early_rel) begin
                    credit_d = '0;
                    rr_ptr_d = scan_ptr;
                end
                if (|elig) begin
                    if (arb_mode_i) begin
                        win = fp_win;
                    end else if (keep_cur) begin
                        win = cur_q;
                    end else begin
                        win      = rr_win;
                        cur_d    = rr_win;
                        credit_d = wgt[rr_win];
                    end
                    state_d  = ISSUE;
                    valid_d  = 1'b1;
                    mode_d   = arb_mode_i;
                    id_d     = win;
                    onehot_d = CHN_NUM'(1) << win;
                end
            end
            ISSUE: begin
                if (gnt_ready_i) begin
                    state_d  = IDLE;
                    valid_d  = 1'b0;
                    onehot_d = '0;
                    if (!mode_q) begin
                        if (credit_q != '0)
                            credit_d = credit_q - 1'b1;
                        if (credit_q <= ARB_W'(1))
                            rr_ptr_d = inc_id(cur_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            id_q     <= '0;
            onehot_q <= '0;
            rr_ptr_q <= '0;
            cur_q    <= '0;
            credit_q <= '0;
            mode_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            id_q     <= id_d;
            onehot_q <= onehot_d;
            rr_ptr_q <= rr_ptr_d;
            cur_q    <= cur_d;
            credit_q <= credit_d;
            mode_q   <= mode_d;
        end
    end

    assign gnt_valid_o  = valid_q;
    assign gnt_id_o     = id_q;
    assign gnt_onehot_o = onehot_q;

endmodule

// File: tb/tb_adma_chn_wrr_sched.sv
// Directed bench for adma_chn_wrr_sched: reset, WRR sequencing, zero weight,
// backpressure, fixed-priority mode with early release, and mid-grant reset.
module tb_adma_chn_wrr_sched;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [3:0]  chn_req = '0;
    logic [11:0] chn_wgt = '0;
    logic        arb_mode = 1'b0;
    logic        gnt_valid;
    logic        gnt_ready = 1'b0;
    logic [1:0]  gnt_id;
    logic [3:0]  gnt_onehot;

    int total = 0;
    int bad = 0;

    always #5 aclk = ~aclk;

    adma_chn_wrr_sched dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .chn_req_i   (chn_req),
        .chn_wgt_i   (chn_wgt),
        .arb_mode_i  (arb_mode),
        .gnt_valid_o (gnt_valid),
        .gnt_ready_i (gnt_ready),
        .gnt_id_o    (gnt_id),
        .gnt_onehot_o(gnt_onehot)
    );

    function automatic logic [11:0] w4(input int w0, input int w1, input int w2, input int w3);
        return {3'(w3), 3'(w2), 3'(w1), 3'(w0)};
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic hold_reset(input logic [3:0] req, input logic [11:0] wgt,
                              input logic mode, input logic rdy);
        aresetn   = 1'b0;
        chn_req   = req;
        chn_wgt   = wgt;
        arb_mode  = mode;
        gnt_ready = rdy;
        @(negedge aclk);
        @(negedge aclk);
    endtask

    task automatic test_reset();
        hold_reset(4'b1111, w4(1, 1, 1, 1), 1'b0, 1'b0);
        total++;
        if (gnt_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_valid got=%b want=0", gnt_valid);
        end
        total++;
        if (gnt_id !== 2'd0) begin
            bad++;
            $display("FAIL rst_id got=%0d want=0", gnt_id);
        end
        total++;
        if (gnt_onehot !== 4'b0000) begin
            bad++;
            $display("FAIL rst_onehot got=%b want=0000", gnt_onehot);
        end
        aresetn = 1'b1;
        tick();
        total++;
        if (gnt_valid !== 1'b1 || gnt_id !== 2'd0 || gnt_onehot !== 4'b0001) begin
            bad++;
            $display("FAIL rst_first got=%b/%0d/%b want=1/0/0001", gnt_valid, gnt_id, gnt_onehot);
        end
    endtask

    task automatic test_wrr_seq();
        int exp_id [10] = '{0, 1, 1, 2, 2, 2, 3, 0, 1, 1};
        int g = 0;
        logic ev;
        hold_reset(4'b1111, w4(1, 2, 3, 1), 1'b0, 1'b1);
        aresetn = 1'b1;
        for (int j = 0; j < 20; j++) begin
            tick();
            ev = (j % 2 == 0);
            total++;
            if (gnt_valid !== ev) begin
                bad++;
                $display("FAIL wrr_valid cyc=%0d got=%b want=%b", j, gnt_valid, ev);
            end
            if (ev && g < 10) begin
                total++;
                if (gnt_id !== 2'(exp_id[g]) || gnt_onehot !== (4'b0001 << exp_id[g])) begin
                    bad++;
                    $display("FAIL wrr_id n=%0d got=%0d/%b want=%0d", g, gnt_id, gnt_onehot, exp_id[g]);
                end
                g++;
            end
        end
    endtask

    task automatic test_zero_weight();
        int exp_id [6] = '{0, 1, 3, 0, 1, 3};
        int g = 0;
        hold_reset(4'b1111, w4(1, 1, 0, 1), 1'b0, 1'b1);
        aresetn = 1'b1;
        for (int j = 0; j < 12; j++) begin
            tick();
            total++;
            if (gnt_onehot === 4'b0100) begin
                bad++;
                $display("FAIL zw_ch2 cyc=%0d got=%b want!=0100", j, gnt_onehot);
            end
            if (j % 2 == 0) begin
                total++;
                if (gnt_valid !== 1'b1 || gnt_id !== 2'(exp_id[g])) begin
                    bad++;
                    $display("FAIL zw_id n=%0d got=%b/%0d want=1/%0d", g, gnt_valid, gnt_id, exp_id[g]);
                end
                g++;
            end
        end
    endtask

    task automatic test_backpressure();
        hold_reset(4'b1111, w4(1, 1, 1, 1), 1'b0, 1'b0);
        aresetn = 1'b1;
        tick();
        total++;
        if (gnt_valid !== 1'b1 || gnt_id !== 2'd0) begin
            bad++;
            $display("FAIL bp_first got=%b/%0d want=1/0", gnt_valid, gnt_id);
        end
        gnt_ready = 1'b1;
        tick();
        gnt_ready = 1'b0;
        tick();
        for (int c = 1; c <= 5; c++) begin
            if (c == 2)
                chn_req = 4'b1101;
            if (c > 1)
                tick();
            total++;
            if (gnt_valid !== 1'b1 || gnt_id !== 2'd1 || gnt_onehot !== 4'b0010) begin
                bad++;
                $display("FAIL bp_hold cyc=%0d got=%b/%0d/%b want=1/1/0010", c, gnt_valid, gnt_id, gnt_onehot);
            end
        end
        gnt_ready = 1'b1;
        tick();
        total++;
        if (gnt_valid !== 1'b0 || gnt_onehot !== 4'b0000) begin
            bad++;
            $display("FAIL bp_hs got=%b/%b want=0/0000", gnt_valid, gnt_onehot);
        end
        tick();
        total++;
        if (gnt_valid !== 1'b1 || gnt_id !== 2'd2) begin
            bad++;
            $display("FAIL bp_next got=%b/%0d want=1/2", gnt_valid, gnt_id);
        end
    endtask

    task automatic test_mode_release();
        hold_reset(4'b1010, w4(1, 3, 1, 1), 1'b1, 1'b1);
        aresetn = 1'b1;
        for (int j = 0; j < 8; j++) begin
            tick();
            if (j % 2 == 0) begin
                total++;
                if (gnt_valid !== 1'b1 || gnt_id !== 2'd1) begin
                    bad++;
                    $display("FAIL fp_id cyc=%0d got=%b/%0d want=1/1", j, gnt_valid, gnt_id);
                end
            end
        end
        arb_mode = 1'b0;
        tick();
        total++;
        if (gnt_valid !== 1'b1 || gnt_id !== 2'd1) begin
            bad++;
            $display("FAIL er_first got=%b/%0d want=1/1", gnt_valid, gnt_id);
        end
        tick();
        chn_req = 4'b1000;
        tick();
        total++;
        if (gnt_valid !== 1'b1 || gnt_id !== 2'd3) begin
            bad++;
            $display("FAIL er_switch got=%b/%0d want=1/3", gnt_valid, gnt_id);
        end
        for (int r = 0; r < 3; r++) begin
            tick();
            tick();
            total++;
            if (gnt_valid !== 1'b1 || gnt_id !== 2'd3) begin
                bad++;
                $display("FAIL er_stay n=%0d got=%b/%0d want=1/3", r, gnt_valid, gnt_id);
            end
        end
        tick();
        chn_req = 4'b1010;
        tick();
        total++;
        if (gnt_valid !== 1'b1 || gnt_id !== 2'd1) begin
            bad++;
            $display("FAIL er_back got=%b/%0d want=1/1", gnt_valid, gnt_id);
        end
    endtask

    task automatic test_mid_reset();
        hold_reset(4'b1111, w4(1, 1, 1, 1), 1'b0, 1'b0);
        aresetn = 1'b1;
        tick();
        tick();
        tick();
        total++;
        if (gnt_valid !== 1'b1 || gnt_id !== 2'd0) begin
            bad++;
            $display("FAIL mr_pend got=%b/%0d want=1/0", gnt_valid, gnt_id);
        end
        #2;
        aresetn = 1'b0;
        #1;
        total++;
        if (gnt_valid !== 1'b0 || gnt_onehot !== 4'b0000) begin
            bad++;
            $display("FAIL mr_async got=%b/%b want=0/0000", gnt_valid, gnt_onehot);
        end
        @(negedge aclk);
        gnt_ready = 1'b1;
        aresetn = 1'b1;
        tick();
        total++;
        if (gnt_valid !== 1'b1 || gnt_id !== 2'd0) begin
            bad++;
            $display("FAIL mr_restart got=%b/%0d want=1/0", gnt_valid, gnt_id);
        end
        tick();
        tick();
        total++;
        if (gnt_valid !== 1'b1 || gnt_id !== 2'd1) begin
            bad++;
            $display("FAIL mr_second got=%b/%0d want=1/1", gnt_valid, gnt_id);
        end
    endtask

    initial begin
        test_reset();
        test_wrr_seq();
        test_zero_weight();
        test_backpressure();
        test_mode_release();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adma_chn_wrr_sched.md
# adma_chn_wrr_sched

Parametrised weighted-round-robin channel scheduler for the multi-channel AXI DMA. It sits between the channel manager and the read host. Each cycle it picks one eligible DMA channel and issues one burst grant on a valid/ready handshake. It supports any channel count, a per-channel arbitration weight, and a run-time fixed-priority mode.

## Interface
- `CHN_NUM`, 4, number of DMA channels (≥2)
- `ARB_W`, 3, width of each channel weight and of the credit counter
- `CHN_ID_W`, `$clog2(CHN_NUM)`, grant ID width (derived localparam, not overridable)

Clock and reset are fixed: one clock `aclk`; reset `aresetn` is asynchronous and active-low.

- `aclk`  in  1  clock
- `aresetn`  in  1  asynchronous active-low reset
- `chn_req_i`  in  CHN_NUM  bit n: channel n has a burst pending
- `chn_wgt_i`  in  CHN_NUM*ARB_W  weight of channel n in bits [n*ARB_W +: ARB_W]; 0 disables the channel
- `arb_mode_i`  in  1  0 = weighted round robin (WRR); 1 = fixed priority, channel 0 highest
- `gnt_valid_o`  out  1  grant offered
- `gnt_ready_i`  in  1  downstream accepts the grant
- `gnt_id_o`  out  CHN_ID_W  granted channel index
- `gnt_onehot_o`  out  CHN_NUM  one-hot of `gnt_id_o`; all zero when `gnt_valid_o`=0

## Operation
- Eligible channel n: `chn_req_i[n]`=1 and weight[n]≠0.
- State machine has two states, IDLE and ISSUE.
- IDLE:
  - No channel eligible: stay in IDLE.
  - Otherwise select a winner, register it into `gnt_id_o` and `gnt_onehot_o`, set `gnt_valid_o`=1, and go to ISSUE.
- Winner selection in WRR mode:
  - If the current channel `cur` is still eligible and `credit`≠0, the winner is `cur`.
  - Otherwise the winner is the first eligible channel scanning `rr_ptr`, `rr_ptr`+1, … modulo CHN_NUM. On this switch, load `credit` ← weight[winner] and `cur` ← winner.
- Winner selection in fixed-priority mode: lowest-index eligible channel. `credit` and `rr_ptr` are not modified.
- ISSUE: hold `gnt_valid_o`, `gnt_id_o` and `gnt_onehot_o` stable until `gnt_ready_i`=1.
  - A grant is never retracted, even if `chn_req_i[cur]` or its weight drops while it is pending.
- Handshake (valid and ready both 1):
  - Return to IDLE and clear `gnt_valid_o` and `gnt_onehot_o`.
  - In WRR mode, decrement `credit`. If it reaches 0, set `rr_ptr` ← (cur+1) mod CHN_NUM.
- Credit arithmetic:
  - Unsigned, ARB_W bits, saturating at 0.
  - Weight w gives at most w consecutive grants to a channel before rotation.
  - The maximum weight is 2^ARB_W−1.
- Early release: if `cur` is ineligible in IDLE while `credit`≠0, discard the remaining credit and set `rr_ptr` ← (cur+1) mod CHN_NUM before scanning.
- `arb_mode_i` and `chn_wgt_i` are sampled only in IDLE.
  - Changing them while in ISSUE has no effect on the pending grant.
  - A weight change on `cur` takes effect at that channel's next credit load.
- Reset values:
  - IDLE state.
  - `gnt_valid_o`=0, `gnt_id_o`=0, `gnt_onehot_o`=0.
  - `rr_ptr`=0, `cur`=0, `credit`=0.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- Request latency: an eligible request seen in IDLE at cycle t gives `gnt_valid_o`=1 at cycle t+1.
- Handshake at cycle t: `gnt_valid_o`=0 at t+1 (IDLE bubble), next grant no earlier than t+2.
  - Peak rate is one grant per 2 cycles.
- Handshake at t with `gnt_ready_i` already high at the valid's first cycle is legal; valid is high for exactly 1 cycle.
- Asynchronous reset asserted during ISSUE:
  - `gnt_valid_o` drops without waiting for the clock.
  - The grant is lost; the downstream must be held in reset together with this block.
- All CHN_NUM channels requesting with non-zero weights: no channel waits longer than sum(weights)−weight[n] grants (starvation bound).

## Test plan
- Reset: assert `aresetn`=0 with `chn_req_i`=4'b1111 → all outputs 0. Release reset → first `gnt_valid_o` 1 cycle after release, with `gnt_id_o`=0.
- WRR weights {c0=1, c1=2, c2=3, c3=1}, all requesting, `gnt_ready_i` tied high → grant ID sequence 0,1,1,2,2,2,3,0,1,1…, one grant every 2 cycles.
- Channel 2 weight 0, all others weight 1, all requesting → sequence 0,1,3,0,1,3; `gnt_onehot_o` never equals 4'b0100.
- Backpressure: hold `gnt_ready_i` low 5 cycles during a grant to ch1 and drop `chn_req_i[1]` in cycle 2 → `gnt_valid_o`=1, `gnt_id_o`=1 and `gnt_onehot_o`=4'b0010 stable for all 5 cycles; handshake on cycle 6.
- Mode and early release:
  - `arb_mode_i`=1 with `chn_req_i`=4'b1010 → ch1 granted repeatedly.
  - Switch to WRR with ch1 weight 3; ch1 drops its request after 1 grant → next grant goes to ch3 (pointer advanced), never back to ch1 until it re-requests.
- Mid-operation reset: assert `aresetn` low during ISSUE → `gnt_valid_o` low in the same cycle; after release the scan restarts from ch0.
